// File: rtl/serialrx_pkg.sv
// serialrx_pkg: shared types and constants for the serialrx UART receiver.
package serialrx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // STATUS register bit positions
  localparam int STAT_VALID  = 0;
  localparam int STAT_FERR   = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_LVL_LO = 4;
  localparam int STAT_LVL_HI = 6;

  // wb_addr bit selecting DATA (0) or STATUS (1)
  localparam int ADDR_SEL_BIT = 2;

  localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/serialrx_fifo.sv
// serialrx_fifo: small synchronous FIFO holding received bytes.
// A pop on a full FIFO frees a slot for a push in the same cycle.
module serialrx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_push_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_pop_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full     = (r_level == LW'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_pop_data = r_mem[r_rptr];
  assign w_do_pop   = i_pop & ~o_empty;
  assign w_do_push  = i_push & (~o_full | w_do_pop);

  // storage write, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_data;
  end

  // pointers wrap naturally at DEPTH; level tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
    end
  end

endmodule

// File: rtl/serialrx.sv
// serialrx: UART receiver with Wishbone slave port.
// Build option SERIALRX_FIFO_EN: 4-entry receive FIFO; otherwise a single
// holding register.
//
// state    | meaning
// ST_IDLE  | line idle, waiting for a falling edge on rx_s
// ST_START | counting to mid start bit, then validating it
// ST_DATA  | sampling FRAME data bits, LSB first
// ST_STOP  | sampling the stop bit, then push or flag framing error
module serialrx
  import serialrx_pkg::*;
#(
  parameter int DIVIDE = 2,
  parameter int FRAME  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data_w,
  output logic [31:0] wb_data_r,
  input  logic        wb_we,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic        wb_stall,
  output logic        rx_valid
);

  localparam int DW = $clog2(DIVIDE);
  localparam int BW = $clog2(FRAME);
  // the detection cycle in IDLE is already the first cycle of the start bit
  localparam logic [DW-1:0] DIV_HALF = DW'(DIVIDE / 2 - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);

  logic             r_sync1, r_rx_s;
  state_t           r_state, w_state_nxt;
  logic [DW-1:0]    r_div, w_div_nxt;
  logic [BW-1:0]    r_bit, w_bit_nxt;
  logic [FRAME-1:0] r_shift, w_shift_nxt;
  logic             w_push, w_ferr_set;
  logic [7:0]       w_byte, w_head;
  logic             w_full, w_empty, w_pop;
  logic [2:0]       w_level;
  logic             w_req, w_rd_data, w_rd_stat, w_wr_stat;
  logic             r_ferr, r_ovr, r_ack;
  logic [31:0]      r_data_r, w_status;
  logic             w_unused;

  assign w_unused = ^{wb_addr[31:3], wb_addr[1:0], wb_data_w[31:3], wb_data_w[0]};

  // two-flop synchroniser, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_rx_s  <= r_sync1;
    end
  end

  // FSM and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // next-state, bit sampling and push/framing-error strobes
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = ST_START;
          w_div_nxt   = '0;
        end
      end
      ST_START: begin
        if (r_div == DIV_HALF) begin
          w_div_nxt = '0;
          w_bit_nxt = '0;
          w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_div == DIV_LAST) begin
          w_shift_nxt[r_bit] = r_rx_s;
          w_div_nxt = '0;
          if (r_bit == BIT_LAST) w_state_nxt = ST_STOP;
          else                   w_bit_nxt   = r_bit + 1'b1;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      ST_STOP: begin
        if (r_div == DIV_LAST) begin
          w_push      = r_rx_s;
          w_ferr_set  = ~r_rx_s;
          w_div_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_byte    = 8'(r_shift);
  assign w_req     = wb_stb & wb_cyc;
  assign w_rd_data = w_req & ~wb_we & ~wb_addr[ADDR_SEL_BIT];
  assign w_rd_stat = w_req & ~wb_we &  wb_addr[ADDR_SEL_BIT];
  assign w_wr_stat = w_req &  wb_we &  wb_addr[ADDR_SEL_BIT];
  assign w_pop     = w_rd_data & ~w_empty;

`ifdef SERIALRX_FIFO_EN
  serialrx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_data(w_byte),
    .i_pop      (w_pop),
    .o_pop_data (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );
`else
  logic       r_hold_v;
  logic [7:0] r_hold;

  assign w_head  = r_hold;
  assign w_full  = r_hold_v;
  assign w_empty = ~r_hold_v;
  assign w_level = {2'b00, r_hold_v};

  // single holding register; a same-cycle pop makes room for the push
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_v <= 1'b0;
      r_hold   <= '0;
    end else if (w_push && (!r_hold_v || w_pop)) begin
      r_hold_v <= 1'b1;
      r_hold   <= w_byte;
    end else if (w_pop) begin
      r_hold_v <= 1'b0;
    end
  end
`endif

  // sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_ferr <= w_ferr_set | (r_ferr & ~(w_wr_stat & wb_data_w[STAT_FERR]));
      r_ovr  <= (w_push & w_full & ~w_pop) | (r_ovr & ~(w_wr_stat & wb_data_w[STAT_OVR]));
    end
  end

  // STATUS word assembly
  always_comb begin
    w_status = '0;
    w_status[STAT_VALID] = ~w_empty;
    w_status[STAT_FERR]  = r_ferr;
    w_status[STAT_OVR]   = r_ovr;
    w_status[STAT_LVL_HI:STAT_LVL_LO] = w_level;
  end

  // registered bus response, ack exactly one cycle after each request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack    <= 1'b0;
      r_data_r <= '0;
    end else begin
      r_ack <= w_req;
      if (w_rd_data)      r_data_r <= {24'd0, (w_empty ? 8'd0 : w_head)};
      else if (w_rd_stat) r_data_r <= w_status;
      else                r_data_r <= '0;
    end
  end

  assign wb_ack    = r_ack;
  assign wb_data_r = r_data_r;
  assign wb_stall  = 1'b0;
  assign rx_valid  = ~w_empty;

endmodule
